// File: rtl/vga_sink_monitor_if.sv
// ----------------------------------------------------------------------------
// vga_sink_monitor_if
//   Video bus between a VGA timing/pattern source and vga_sink_monitor.
//   Signals:
//     hsync, vsync    : sync pulses (polarity set by the monitor parameters)
//     hblank, vblank  : high during horizontal / vertical blanking
//     r, g, b         : 8-bit pixel colour
//   Modports:
//     master : the video source, which drives every signal
//     slave  : the monitor, which only samples
// ----------------------------------------------------------------------------
interface vga_sink_monitor_if;
  logic       hsync;
  logic       vsync;
  logic       hblank;
  logic       vblank;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  modport master (output hsync, vsync, hblank, vblank, r, g, b);
  modport slave  (input  hsync, vsync, hblank, vblank, r, g, b);
endinterface

// File: rtl/vga_sink_monitor.sv
// ----------------------------------------------------------------------------
// vga_sink_monitor
//   Receive-side VGA checker. It measures line and frame geometry, checks that
//   the timing repeats line-to-line and frame-to-frame, and builds a 16-bit
//   signature over the visible pixels of every frame.
//
//   Parameters:
//     HSYNC_POL, VSYNC_POL : active level of hsync / vsync (0 = active-low)
//     CW                   : width of the geometry counters and outputs
//     TIMEOUT              : clocks without an hsync leading edge before the
//                            monitor drops back to SEEK
//
//   Ports:
//     clk          : clock
//     n_rst        : asynchronous reset, active-high
//     vid          : video bus (slave modport of vga_sink_monitor_if)
//     h_total      : clocks per line (last line of the last completed frame)
//     h_active     : non-hblank clocks of that line
//     v_total      : lines per frame
//     v_active     : active lines per frame
//     signature    : pixel signature of the last completed frame
//     frame_done   : one-cycle pulse when the outputs above update
//     locked       : timing stable frame-to-frame
//     mismatch_cnt : saturating count of lock losses
//
//   Optional build macro VGA_MON_SYNC_WIDTH_EN adds:
//     hsync_width  : clocks hsync stays active after its leading edge,
//                    measured on the last line of the frame
//     vsync_width  : hsync leading edges counted while vsync is active
//   Both join the lock comparison.
// ----------------------------------------------------------------------------
module vga_sink_monitor #(
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CW        = 12,
  parameter int   TIMEOUT   = 4095
) (
  input  logic               clk,
  input  logic               n_rst,
  vga_sink_monitor_if.slave  vid,
  output logic [CW-1:0]      h_total,
  output logic [CW-1:0]      h_active,
  output logic [CW-1:0]      v_total,
  output logic [CW-1:0]      v_active,
  output logic [15:0]        signature,
  output logic               frame_done,
  output logic               locked,
  output logic [7:0]         mismatch_cnt
`ifdef VGA_MON_SYNC_WIDTH_EN
  ,
  output logic [CW-1:0]      hsync_width,
  output logic [CW-1:0]      vsync_width
`endif
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  typedef enum logic [1:0] {SEEK, MEASURE, CHECK} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // --------------------------------------------------------------------------
  // Edge detection
  // --------------------------------------------------------------------------
  logic hs_prev_q, vs_prev_q, hb_prev_q;
  logic hs_act, vs_act, hle, vle, act_start, pix_vld;

  assign hs_act    = (vid.hsync == HSYNC_POL);
  assign vs_act    = (vid.vsync == VSYNC_POL);
  assign hle       = hs_act & (hs_prev_q != HSYNC_POL);
  assign vle       = vs_act & (vs_prev_q != VSYNC_POL);
  // Only active starts inside the vertical active region count as lines.
  assign act_start = hb_prev_q & ~vid.hblank & ~vid.vblank;
  assign pix_vld   = ~vid.hblank & ~vid.vblank;

  // --------------------------------------------------------------------------
  // Measurement counters
  // --------------------------------------------------------------------------
  logic [CW-1:0] hc_q, hc_d, ha_q, ha_d;
  logic [CW-1:0] line_len_q, line_len_d, line_act_q, line_act_d;
  logic [CW-1:0] first_len_q, first_len_d;
  logic          first_vld_q, first_vld_d;
  logic          line_err_q, line_err_d;
  logic [CW-1:0] vc_q, vc_d, va_q, va_d;
  logic [15:0]   sig_q, sig_d, sig_base;
  logic [TW-1:0] to_q, to_d;
  logic          timeout;
`ifdef VGA_MON_SYNC_WIDTH_EN
  logic [CW-1:0] hw_q, hw_d, vw_q, vw_d;
  logic          hw_run_q, hw_run_d;
`endif

  // NOTE: every variable of an always_comb block gets a value before any
  // condition touches it; a path that leaves one unassigned infers a latch.
  always_comb begin
    hc_d        = hle ? CNT_ONE : sat_inc(hc_q);
    ha_d        = ha_q;
    line_len_d  = hle ? hc_q : line_len_q;
    line_act_d  = hle ? ha_q : line_act_q;
    first_len_d = first_len_q;
    first_vld_d = first_vld_q;
    line_err_d  = line_err_q;
    vc_d        = vc_q;
    va_d        = va_q;
    sig_base    = vle ? 16'h0000 : sig_q;
    to_d        = hle ? '0 : ((to_q == TO_LAST) ? to_q : to_q + TO_ONE);

    if (hle)              ha_d = vid.hblank ? '0 : CNT_ONE;
    else if (!vid.hblank) ha_d = sat_inc(ha_q);

    // The first line of each frame is the reference every later line must
    // match. An edge coincident with VLE already belongs to the new frame.
    if (vle) begin
      first_vld_d = hle;
      line_err_d  = 1'b0;
      if (hle) first_len_d = hc_q;
    end else if (hle) begin
      if (!first_vld_q) begin
        first_vld_d = 1'b1;
        first_len_d = hc_q;
      end else if (hc_q != first_len_q) begin
        line_err_d = 1'b1;
      end
    end

    if (vle)      vc_d = hle ? CNT_ONE : '0;
    else if (hle) vc_d = sat_inc(vc_q);

    if (vle)            va_d = act_start ? CNT_ONE : '0;
    else if (act_start) va_d = sat_inc(va_q);

    // A pixel on the VLE cycle starts the new frame's signature.
    sig_d = pix_vld ? ({sig_base[14:0], sig_base[15]} ^ {vid.r, vid.g ^ vid.b})
                    : sig_base;

`ifdef VGA_MON_SYNC_WIDTH_EN
    hw_d     = hw_q;
    hw_run_d = hw_run_q;
    vw_d     = vw_q;
    if (hle) begin
      hw_d     = CNT_ONE;
      hw_run_d = 1'b1;
    end else if (hw_run_q && hs_act) begin
      hw_d = sat_inc(hw_q);
    end else begin
      hw_run_d = 1'b0;
    end
    if (vle)                vw_d = (hle && vs_act) ? CNT_ONE : '0;
    else if (hle && vs_act) vw_d = sat_inc(vw_q);
`endif
  end

  assign timeout = ~hle & (to_q == TO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      hs_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      hb_prev_q   <= 1'b0;
      hc_q        <= '0;
      ha_q        <= '0;
      line_len_q  <= '0;
      line_act_q  <= '0;
      first_len_q <= '0;
      first_vld_q <= 1'b0;
      line_err_q  <= 1'b0;
      vc_q        <= '0;
      va_q        <= '0;
      sig_q       <= '0;
      to_q        <= '0;
`ifdef VGA_MON_SYNC_WIDTH_EN
      hw_q        <= '0;
      hw_run_q    <= 1'b0;
      vw_q        <= '0;
`endif
    end else begin
      hs_prev_q   <= vid.hsync;
      vs_prev_q   <= vid.vsync;
      hb_prev_q   <= vid.hblank;
      hc_q        <= hc_d;
      ha_q        <= ha_d;
      line_len_q  <= line_len_d;
      line_act_q  <= line_act_d;
      first_len_q <= first_len_d;
      first_vld_q <= first_vld_d;
      line_err_q  <= line_err_d;
      vc_q        <= vc_d;
      va_q        <= va_d;
      sig_q       <= sig_d;
      to_q        <= to_d;
`ifdef VGA_MON_SYNC_WIDTH_EN
      hw_q        <= hw_d;
      hw_run_q    <= hw_run_d;
      vw_q        <= vw_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Frame results and lock FSM
  // --------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic          latch_en, geom_same;
  logic          locked_q, locked_d, frame_done_q;
  logic [7:0]    mm_q, mm_d;
  logic [CW-1:0] h_lat, a_lat;
  logic [CW-1:0] h_total_q, h_active_q, v_total_q, v_active_q;
  logic [15:0]   signature_q;
`ifdef VGA_MON_SYNC_WIDTH_EN
  logic [CW-1:0] hsync_width_q, vsync_width_q;
`endif

  // If an HLE coincides with VLE, the line it closes is the frame's last line.
  assign h_lat = hle ? hc_q : line_len_q;
  assign a_lat = hle ? ha_q : line_act_q;

  always_comb begin
    geom_same = (h_lat == h_total_q) && (a_lat == h_active_q) &&
                (vc_q == v_total_q) && (va_q == v_active_q);
`ifdef VGA_MON_SYNC_WIDTH_EN
    geom_same = geom_same && (hw_q == hsync_width_q) && (vw_q == vsync_width_q);
`endif
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    locked_d = locked_q;
    mm_d     = mm_q;
    if (timeout) begin
      state_d  = SEEK;
      locked_d = 1'b0;
    end else if (vle) begin
      case (state_q)
        SEEK:    state_d = MEASURE;
        MEASURE: begin
          latch_en = 1'b1;
          state_d  = CHECK;
        end
        CHECK: begin
          latch_en = 1'b1;
          if (geom_same && !line_err_q) begin
            locked_d = 1'b1;
          end else begin
            if (locked_q && mm_q != 8'hFF) mm_d = mm_q + 8'd1;
            locked_d = 1'b0;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) state_q <= SEEK;
    else       state_q <= state_d;
  end

  // NOTE: the result registers are reset too, so a mid-frame reset clears the
  // outputs on the spot rather than at the next frame boundary.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      h_total_q     <= '0;
      h_active_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
      signature_q   <= '0;
      frame_done_q  <= 1'b0;
      locked_q      <= 1'b0;
      mm_q          <= '0;
`ifdef VGA_MON_SYNC_WIDTH_EN
      hsync_width_q <= '0;
      vsync_width_q <= '0;
`endif
    end else begin
      frame_done_q <= latch_en;
      locked_q     <= locked_d;
      mm_q         <= mm_d;
      if (latch_en) begin
        h_total_q     <= h_lat;
        h_active_q    <= a_lat;
        v_total_q     <= vc_q;
        v_active_q    <= va_q;
        signature_q   <= sig_q;
`ifdef VGA_MON_SYNC_WIDTH_EN
        hsync_width_q <= hw_q;
        vsync_width_q <= vw_q;
`endif
      end
    end
  end

  assign h_total      = h_total_q;
  assign h_active     = h_active_q;
  assign v_total      = v_total_q;
  assign v_active     = v_active_q;
  assign signature    = signature_q;
  assign frame_done   = frame_done_q;
  assign locked       = locked_q;
  assign mismatch_cnt = mm_q;
`ifdef VGA_MON_SYNC_WIDTH_EN
  assign hsync_width  = hsync_width_q;
  assign vsync_width  = vsync_width_q;
`endif

endmodule

// File: tb/tb_vga_sink_monitor.sv
// ----------------------------------------------------------------------------
// tb_vga_sink_monitor
//   Directed bench for vga_sink_monitor. A small video source drives scaled
//   VGA-style frames (active-low syncs, VLE at the start of a line, HLE after
//   the front porch); frame_done pulses are captured on the falling edge and
//   compared with hand-computed geometry and signatures.
// ----------------------------------------------------------------------------
module tb_vga_sink_monitor;
  localparam int CW = 12;

  typedef struct packed {
    int htot; int hact; int hfp; int hsw;
    int vtot; int vact; int vfp; int vsw;
  } mode_t;

  // 40x20 frame, 32x16 visible, 6-clock hsync, 2-line vsync.
  localparam mode_t M_MAIN = '{40, 32, 2, 6, 20, 16, 1, 2};
  // 8x4 frame, 4x2 visible: used for the long saturation run.
  localparam mode_t M_TINY = '{8, 4, 1, 2, 4, 2, 0, 1};
  // 120-clock line with a 96-clock hsync, 2-line vsync.
  localparam mode_t M_WIDE = '{120, 16, 4, 96, 6, 2, 1, 2};

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  vga_sink_monitor_if vif ();

  logic [CW-1:0] h_total, h_active, v_total, v_active;
  logic [15:0]   signature;
  logic          frame_done, locked;
  logic [7:0]    mismatch_cnt;
`ifdef VGA_MON_SYNC_WIDTH_EN
  logic [CW-1:0] hsync_width, vsync_width;
`endif

  vga_sink_monitor #(
    .HSYNC_POL (1'b0),
    .VSYNC_POL (1'b0),
    .CW        (CW),
    .TIMEOUT   (4095)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .vid          (vif),
    .h_total      (h_total),
    .h_active     (h_active),
    .v_total      (v_total),
    .v_active     (v_active),
    .signature    (signature),
    .frame_done   (frame_done),
    .locked       (locked),
    .mismatch_cnt (mismatch_cnt)
`ifdef VGA_MON_SYNC_WIDTH_EN
    ,
    .hsync_width  (hsync_width),
    .vsync_width  (vsync_width)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Snapshot of the outputs at every frame_done pulse.
  int            fd_cnt = 0;
  logic [CW-1:0] fd_ht, fd_ha, fd_vt, fd_va;
  logic [15:0]   fd_sig;
  logic          fd_lock;
  logic [7:0]    fd_mm;
`ifdef VGA_MON_SYNC_WIDTH_EN
  logic [CW-1:0] fd_hw, fd_vw;
`endif

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_cnt  <= fd_cnt + 1;
      fd_ht   <= h_total;
      fd_ha   <= h_active;
      fd_vt   <= v_total;
      fd_va   <= v_active;
      fd_sig  <= signature;
      fd_lock <= locked;
      fd_mm   <= mismatch_cnt;
`ifdef VGA_MON_SYNC_WIDTH_EN
      fd_hw   <= hsync_width;
      fd_vw   <= vsync_width;
`endif
    end
  end

  // One clock of video at position (x, y); inputs change 1 ns after the edge.
  task automatic drive(input mode_t m, input int x, input int y, input logic [7:0] rv);
    vif.hblank = (x >= m.hact);
    vif.vblank = (y >= m.vact);
    vif.hsync  = !((x >= m.hact + m.hfp) && (x < m.hact + m.hfp + m.hsw));
    vif.vsync  = !((y >= m.vact + m.vfp) && (y < m.vact + m.vfp + m.vsw));
    vif.r      = rv;
    vif.g      = 8'h00;
    vif.b      = 8'h00;
    @(posedge clk);
    #1;
  endtask

  // Lines 0..last_y-1; line stretch_y gets one extra blank clock at its end,
  // and pixel (px, py) carries r=0x01.
  task automatic run_frame(input mode_t m, input int stretch_y, input int px,
                           input int py, input int last_y);
    for (int y = 0; y < last_y; y++) begin
      for (int x = 0; x < m.htot; x++) begin
        drive(m, x, y, (x == px && y == py) ? 8'h01 : 8'h00);
        if (y == stretch_y && x == m.htot - 1) drive(m, x, y, 8'h00);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      vif.hsync  = 1'b1;
      vif.vsync  = 1'b1;
      vif.hblank = 1'b1;
      vif.vblank = 1'b1;
      vif.r      = 8'h00;
      vif.g      = 8'h00;
      vif.b      = 8'h00;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_h_total"},    32'(h_total),      0);
    check({pfx, "_h_active"},   32'(h_active),     0);
    check({pfx, "_v_total"},    32'(v_total),      0);
    check({pfx, "_v_active"},   32'(v_active),     0);
    check({pfx, "_signature"},  32'(signature),    0);
    check({pfx, "_frame_done"}, 32'(frame_done),   0);
    check({pfx, "_locked"},     32'(locked),       0);
    check({pfx, "_mismatch"},   32'(mismatch_cnt), 0);
`ifdef VGA_MON_SYNC_WIDTH_EN
    check({pfx, "_hsync_w"},    32'(hsync_width),  0);
    check({pfx, "_vsync_w"},    32'(vsync_width),  0);
`endif
  endtask

  initial begin
    idle(4);
    @(negedge clk);
    check_zero("rst");
    n_rst = 1'b0;

    // Frame 1 only finds the first VLE; frame 2 is the first measured frame.
    run_frame(M_MAIN, -1, -1, -1, M_MAIN.vtot);
    check("seek_no_fd", 32'(fd_cnt), 0);
    run_frame(M_MAIN, -1, -1, -1, M_MAIN.vtot);
    check("fd1_count",    32'(fd_cnt),  1);
    check("fd1_h_total",  32'(fd_ht),   40);
    check("fd1_h_active", 32'(fd_ha),   32);
    check("fd1_v_total",  32'(fd_vt),   20);
    check("fd1_v_active", 32'(fd_va),   16);
    check("fd1_sig",      32'(fd_sig),  32'h0000);
    check("fd1_locked",   32'(fd_lock), 0);
    run_frame(M_MAIN, -1, -1, -1, M_MAIN.vtot);
    check("fd2_count",    32'(fd_cnt),  2);
    check("fd2_locked",   32'(fd_lock), 1);
    check("fd2_mismatch", 32'(fd_mm),   0);

    // Single pixel: last visible position is never rotated; the first one is
    // rotated 511 times (15 mod 16), i.e. one place right.
    run_frame(M_MAIN, -1, 31, 15, M_MAIN.vtot);
    check("sig_last_pix", 32'(fd_sig), 32'h0100);
    check("sig_last_lock", 32'(fd_lock), 1);
    run_frame(M_MAIN, -1, 0, 0, M_MAIN.vtot);
    check("sig_first_pix", 32'(fd_sig), 32'h0080);

    // One 41-clock line inside the frame drops lock once.
    run_frame(M_MAIN, 5, -1, -1, M_MAIN.vtot);
    check("stretch_count",    32'(fd_cnt),  5);
    check("stretch_locked",   32'(fd_lock), 0);
    check("stretch_mismatch", 32'(fd_mm),   1);
    check("stretch_h_total",  32'(fd_ht),   40);
    run_frame(M_MAIN, -1, -1, -1, M_MAIN.vtot);
    check("relock_locked",   32'(fd_lock), 1);
    check("relock_mismatch", 32'(fd_mm),   1);

    // hsync stalls: drop to SEEK, keep latched results.
    idle(4096);
    check("to_locked",   32'(locked),       0);
    check("to_h_total",  32'(h_total),      40);
    check("to_v_active", 32'(v_active),     16);
    check("to_mismatch", 32'(mismatch_cnt), 1);
    check("to_no_fd",    32'(fd_cnt),       6);
    run_frame(M_MAIN, -1, -1, -1, M_MAIN.vtot);
    check("resume_vle1_no_fd", 32'(fd_cnt), 6);
    run_frame(M_MAIN, -1, -1, -1, M_MAIN.vtot);
    check("resume_vle2_fd",     32'(fd_cnt),  7);
    check("resume_vle2_locked", 32'(fd_lock), 0);
    check("resume_h_total",     32'(fd_ht),   40);
    run_frame(M_MAIN, -1, -1, -1, M_MAIN.vtot);
    check("resume_relock", 32'(fd_lock), 1);

    // Reset in the middle of a frame.
    run_frame(M_MAIN, -1, -1, -1, 10);
    n_rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    idle(3);
    n_rst = 1'b0;
    idle(2);
    check("midrst_no_fd", 32'(fd_cnt), 8);

    // Saturation: each stretched/clean pair costs exactly one lock loss.
    for (int i = 0; i < 3; i++) run_frame(M_TINY, -1, -1, -1, M_TINY.vtot);
    check("tiny_count",    32'(fd_cnt),  10);
    check("tiny_locked",   32'(fd_lock), 1);
    check("tiny_h_total",  32'(fd_ht),   8);
    check("tiny_h_active", 32'(fd_ha),   4);
    check("tiny_v_total",  32'(fd_vt),   4);
    check("tiny_v_active", 32'(fd_va),   2);
    for (int i = 1; i <= 300; i++) begin
      run_frame(M_TINY, 3, -1, -1, M_TINY.vtot);
      run_frame(M_TINY, -1, -1, -1, M_TINY.vtot);
      if (i == 1)   check("sat_mm_1",   32'(mismatch_cnt), 1);
      if (i == 100) check("sat_mm_100", 32'(mismatch_cnt), 100);
    end
    check("sat_mm_255",    32'(mismatch_cnt), 255);
    check("sat_unlocked",  32'(locked),       0);
    run_frame(M_TINY, -1, -1, -1, M_TINY.vtot);
    check("sat_relock",    32'(fd_lock), 1);
    check("sat_mm_held",   32'(fd_mm),   255);

`ifdef VGA_MON_SYNC_WIDTH_EN
    for (int i = 0; i < 3; i++) run_frame(M_WIDE, -1, -1, -1, M_WIDE.vtot);
    check("wide_h_total",     32'(fd_ht), 120);
    check("wide_v_total",     32'(fd_vt), 6);
    check("wide_hsync_width", 32'(fd_hw), 96);
    check("wide_vsync_width", 32'(fd_vw), 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
